// File: rtl/riscv_mem_responder.sv
// riscv_mem_responder
//   Single-outstanding word-addressed memory responder with a valid/ready
//   request channel and a valid/ready response channel. Each accepted request
//   is answered after a programmable latency L. The read is sampled from the
//   array, or the write is committed, on the edge that enters RESP.
//   Addresses outside [ADDR_BASE, ADDR_BASE + 4*DEPTH_WORDS) return rsp_err=1
//   and rsp_rdata=0, and they leave the array untouched.
//
//   Optional build macro: MEM_RESPONDER_RAND_LAT_EN
//     When it is defined, an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5) adds 0..7
//     extra cycles to every transaction. The LFSR steps once per acceptance.
//
//   Ports
//     clk, rst_n             clock, synchronous active-low reset
//     req_valid / req_ready  request handshake (req_ready=1 only in IDLE)
//     req_addr               byte address; bits [1:0] ignored
//     req_wen                1 = write, 0 = read
//     req_wdata, req_wstrb   write data and per-byte enables
//     rsp_valid / rsp_ready  response handshake
//     rsp_rdata              read data (0 for writes and errors)
//     rsp_err                address out of range
module riscv_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // 5 bits covers LATENCY (up to 15) plus up to 7 random cycles.
  localparam int         CNT_W = 5;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   lat_total;

  logic [31:0]        cap_addr;
  logic               cap_wen;
  logic [31:0]        cap_wdata;
  logic [3:0]         cap_wstrb;

  logic [31:0]        op_addr;
  logic               op_wen;
  logic [31:0]        op_wdata;
  logic [3:0]         op_wstrb;
  logic [32:0]        op_off;
  logic               op_in_range;
  logic [IDX_W-1:0]   op_idx;
  logic               accept;
  logic               enter_resp;
  logic [31:0]        rd_next;

  logic [31:0]        mem [DEPTH_WORDS];

  assign accept = (state == IDLE) && req_valid;

`ifdef MEM_RESPONDER_RAND_LAT_EN
  logic [7:0] lfsr;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_ff @(posedge clk) begin
    if (!rst_n)
      lfsr <= 8'hA5;
    else if (accept)
      lfsr <= {lfsr[6:0], lfsr_fb};
  end

  // The extra latency uses the LFSR value from before this acceptance steps it.
  assign lat_total = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
  assign lat_total = CNT_W'(LATENCY);
`endif

  // With L=1, RESP is entered on the acceptance edge itself. On that edge the
  // operation comes straight from the request inputs. Otherwise it comes from
  // the captured copy.
  always_comb begin
    op_addr  = cap_addr;
    op_wen   = cap_wen;
    op_wdata = cap_wdata;
    op_wstrb = cap_wstrb;
    if (state == IDLE) begin
      op_addr  = req_addr;
      op_wen   = req_wen;
      op_wdata = req_wdata;
      op_wstrb = req_wstrb;
    end
  end

  // The range check uses 33-bit arithmetic. An address below the base wraps
  // to a huge offset, so one compare covers both ends. SPAN is a multiple of
  // 4, so the low two address bits cannot move a word across the boundary.
  assign op_off      = {1'b0, op_addr} - {1'b0, ADDR_BASE};
  assign op_in_range = (op_off < SPAN);
  assign op_idx      = op_off[IDX_W+1:2];

  assign enter_resp = ((state == IDLE) && req_valid && (lat_total == CNT_W'(1))) ||
                      ((state == WAIT) && (cnt == CNT_W'(1)));

  assign rd_next = (op_in_range && !op_wen) ? mem[op_idx] : 32'h0;

  // Request capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_addr  <= req_addr;
      cap_wen   <= req_wen;
      cap_wdata <= req_wdata;
      cap_wstrb <= req_wstrb;
    end
  end

  // Array commit. The write is gated by rst_n, so a reset while in WAIT drops
  // the write.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && op_wen && op_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (op_wstrb[b])
          mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cnt       <= lat_total - CNT_W'(1);
            if (lat_total == CNT_W'(1)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rd_next;
              rsp_err   <= !op_in_range;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_next;
            rsp_err   <= !op_in_range;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Testbench for riscv_mem_responder.
// It has three instances with LATENCY 1, 3 and 4. They share the clock and
// reset, and each one has its own request and response signals.
module tb_riscv_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [31:0] req_addr  [3];
  logic [2:0]  req_wen;
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wstrb [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int total = 0;
  int bad   = 0;
  int lat_of [3] = '{1, 3, 4};
`ifdef MEM_RESPONDER_RAND_LAT_EN
  logic [7:0] mlfsr [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_mem_responder #(
      .ADDR_BASE  (32'h8000_0000),
      .DEPTH_WORDS(4096),
      .LATENCY    ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_addr (req_addr[g]),
      .req_wen  (req_wen[g]),
      .req_wdata(req_wdata[g]),
      .req_wstrb(req_wstrb[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
`ifdef MEM_RESPONDER_RAND_LAT_EN
    for (int i = 0; i < 3; i++) mlfsr[i] = 8'hA5;
`endif
  endtask

  // Expected latency of the next transaction on instance i. The model LFSR
  // steps once per acceptance.
  task automatic next_lat(input int i, output int l);
    l = lat_of[i];
`ifdef MEM_RESPONDER_RAND_LAT_EN
    l = l + int'(mlfsr[i][2:0]);
    mlfsr[i] = {mlfsr[i][6:0], mlfsr[i][7] ^ mlfsr[i][5] ^ mlfsr[i][4] ^ mlfsr[i][3]};
`endif
  endtask

  // Runs one transaction on instance i. The call is made #1 after a rising
  // edge while the instance is idle. rsp_ready stays low for 'hold' extra
  // cycles after rsp_valid rises. When noise=1, req_valid stays high with an
  // all-ones write to the same address until the response is taken.
  task automatic txn(input int i, input logic [31:0] a, input logic w,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input int hold, input bit noise,
                     output logic [31:0] rd, output logic er);
    int n;
    int el;
    chk($sformatf("ready_before%0d", i), req_ready[i], 1'b1);
    req_addr[i]  = a;
    req_wen[i]   = w;
    req_wdata[i] = wd;
    req_wstrb[i] = ws;
    req_valid[i] = 1'b1;
    next_lat(i, el);
    @(posedge clk); #1;
    if (noise) begin
      req_wen[i]   = 1'b1;
      req_wdata[i] = 32'hFFFF_FFFF;
      req_wstrb[i] = 4'hF;
    end else begin
      req_valid[i] = 1'b0;
    end
    n = 1;
    while (!rsp_valid[i] && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("rsp_valid%0d", i), rsp_valid[i], 1'b1);
    chk($sformatf("latency%0d", i), n, el);
    rd = rsp_rdata[i];
    er = rsp_err[i];
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("hold_ready%0d", i), req_ready[i], 1'b0);
      @(posedge clk); #1;
      chk($sformatf("hold_valid%0d", i), rsp_valid[i], 1'b1);
      chk($sformatf("hold_rdata%0d", i), rsp_rdata[i], rd);
      chk($sformatf("hold_err%0d", i), rsp_err[i], er);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
    chk($sformatf("idle_ready%0d", i), req_ready[i], 1'b1);
    chk($sformatf("idle_valid%0d", i), rsp_valid[i], 1'b0);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_wen   = '0;
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) begin
      req_addr[i]  = 32'h0;
      req_wdata[i] = 32'h0;
      req_wstrb[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready%0d", i), req_ready[i], 1'b1);
      chk($sformatf("rst_valid%0d", i), rsp_valid[i], 1'b0);
      chk($sformatf("rst_rdata%0d", i), rsp_rdata[i], 32'h0);
      chk($sformatf("rst_err%0d", i), rsp_err[i], 1'b0);
    end

    // Preload and read back word 0 on the L=1 instance.
    txn(0, 32'h8000_0000, 1'b1, 32'h0000_0013, 4'hF, 0, 1'b0, rd, er);
    chk("w_word0_rdata", rd, 32'h0);
    chk("w_word0_err", er, 1'b0);
    txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_word0_rdata", rd, 32'h0000_0013);
    chk("r_word0_err", er, 1'b0);

    // Byte-strobed write.
    txn(0, 32'h8000_0010, 1'b1, 32'h1122_3344, 4'hF, 0, 1'b0, rd, er);
    txn(0, 32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0101, 0, 1'b0, rd, er);
    txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_strb_rdata", rd, 32'h11AD_33EF);

    // wstrb=0 is a no-op without error.
    txn(0, 32'h8000_0010, 1'b1, 32'h0000_0000, 4'b0000, 0, 1'b0, rd, er);
    chk("w_nostrb_err", er, 1'b0);
    txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_nostrb_rdata", rd, 32'h11AD_33EF);

    // Range boundaries.
    txn(0, 32'h8000_3FFC, 1'b1, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, rd, er);
    chk("w_last_err", er, 1'b0);
    txn(0, 32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_last_rdata", rd, 32'hA5A5_5A5A);
    txn(0, 32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_below_err", er, 1'b1);
    chk("r_below_rdata", rd, 32'h0);
    txn(0, 32'h8000_4000, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_above_err", er, 1'b1);
    chk("r_above_rdata", rd, 32'h0);
    txn(0, 32'h8000_4000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd, er);
    chk("w_above_err", er, 1'b1);
    chk("w_above_rdata", rd, 32'h0);
    txn(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_after_oor_w0", rd, 32'h0000_0013);
    txn(0, 32'h8000_3FFC, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_after_oor_last", rd, 32'hA5A5_5A5A);

    // L=3: the response is held for 5 cycles while a stray request stays asserted.
    txn(1, 32'h8000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 0, 1'b0, rd, er);
    txn(1, 32'h8000_0023, 1'b0, 32'h0, 4'h0, 5, 1'b1, rd, er);
    chk("r_l3_rdata", rd, 32'hCAFE_F00D);
    chk("r_l3_err", er, 1'b0);
    txn(1, 32'h8000_0020, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_l3_after_noise", rd, 32'hCAFE_F00D);

    // L=4: a reset two cycles after acceptance drops the write.
    txn(2, 32'h8000_0030, 1'b1, 32'h0102_0304, 4'hF, 0, 1'b0, rd, er);
    req_addr[2]  = 32'h8000_0030;
    req_wen[2]   = 1'b1;
    req_wdata[2] = 32'hFFFF_FFFF;
    req_wstrb[2] = 4'hF;
    req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("rst_wait_valid", rsp_valid[2], 1'b0);
    chk("rst_wait_ready", req_ready[2], 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_wait_valid_later", rsp_valid[2], 1'b0);
    txn(2, 32'h8000_0030, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_rst_unchanged", rd, 32'h0102_0304);

    // After the reset, the array still holds earlier data.
    txn(0, 32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("r_persist_rdata", rd, 32'h11AD_33EF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
